// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave serving a DEPTH x 64-bit SRAM mapped at 0x8000_0000
// Ports: clk_i/rst_i clock and sync active-high reset; aw*/w*/b* write address,
// data and response channels; ar*/r* read address and data channels.
// Bad bursts (WRAP, reserved, size > 3) answer SLVERR and never touch the SRAM;
// beats outside the window answer DECERR, drop writes and return zero data.
module axi4_sram_slave #(
  parameter int DEPTH = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [7:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  input  logic        wlast_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [3:0]  rid_o,
  output logic [63:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] LIM = 32'(DEPTH * 8);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [63:0] mem [DEPTH];
  r_state_e    r_state_q;
  logic [31:0] raddr_q;
  logic [7:0]  rlen_q, rcnt_q;
  logic [2:0]  rsize_q;
  logic        rinc_q, rbad_q;
  logic [3:0]  rid_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  w_state_e    w_state_q;
  logic [31:0] waddr_q;
  logic [7:0]  wlen_q, wcnt_q;
  logic [2:0]  wsize_q;
  logic        winc_q, wbad_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;
  logic [31:0] roff, woff;
  logic        r_inr, w_inr, w_last_beat, w_we;
  logic [1:0]  w_resp_d;
  always_comb begin
    roff = raddr_q - BASE;
    woff = waddr_q - BASE;
    r_inr = raddr_q[31] && roff < LIM;
    w_inr = waddr_q[31] && woff < LIM;
    w_last_beat = wcnt_q == wlen_q;
    // SLVERR is sticky and outranks DECERR across the whole burst
    w_resp_d = (bresp_q == SLVERR || wbad_q || wlast_i != w_last_beat) ? SLVERR :
               (bresp_q == DECERR || !w_inr) ? DECERR : OKAY;
    w_we = w_state_q == W_DATA && wvalid_i && !rst_i && !wbad_q && w_inr;
  end
  assign arready_o = r_state_q == R_IDLE;
  assign rvalid_o  = r_state_q == R_DATA;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
  assign awready_o = w_state_q == W_IDLE;
  assign wready_o  = w_state_q == W_DATA;
  assign bvalid_o  = w_state_q == W_RESP;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  // contents survive reset
  always_ff @(posedge clk_i)
    if (w_we)
      for (int b = 0; b < 8; b++)
        if (wstrb_i[b]) mem[woff[AW+2:3]][b*8 +: 8] <= wdata_i[b*8 +: 8];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rinc_q    <= 1'b0;
      rbad_q    <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (arvalid_i) begin
          raddr_q   <= araddr_i;
          rlen_q    <= arlen_i;
          rcnt_q    <= '0;
          rsize_q   <= arsize_i;
          rinc_q    <= arburst_i == 2'b01;
          rbad_q    <= arburst_i[1] || arsize_i > 3'd3;
          rid_q     <= arid_i;
          r_state_q <= R_READ;
        end
        R_READ: begin
          rresp_q   <= rbad_q ? SLVERR : r_inr ? OKAY : DECERR;
          rdata_q   <= (!rbad_q && r_inr) ? mem[roff[AW+2:3]] : '0;
          rlast_q   <= rcnt_q == rlen_q;
          r_state_q <= R_DATA;
        end
        R_DATA: if (rready_i) begin
          rcnt_q    <= rcnt_q + 8'd1;
          raddr_q   <= rinc_q ? raddr_q + (32'd1 << rsize_q) : raddr_q;
          r_state_q <= rlast_q ? R_IDLE : R_READ;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      winc_q    <= 1'b0;
      wbad_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (awvalid_i) begin
          waddr_q   <= awaddr_i;
          wlen_q    <= awlen_i;
          wcnt_q    <= '0;
          wsize_q   <= awsize_i;
          winc_q    <= awburst_i == 2'b01;
          wbad_q    <= awburst_i[1] || awsize_i > 3'd3;
          bid_q     <= awid_i;
          bresp_q   <= OKAY;
          w_state_q <= W_DATA;
        end
        W_DATA: if (wvalid_i) begin
          bresp_q   <= w_resp_d;
          wcnt_q    <= wcnt_q + 8'd1;
          waddr_q   <= winc_q ? waddr_q + (32'd1 << wsize_q) : waddr_q;
          w_state_q <= w_last_beat ? W_RESP : W_DATA;
        end
        W_RESP: if (bready_i) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
endmodule
